// File: rtl/uart_cmd_decoder_if.sv
// Frame-in / command-out bundle for the UART command decoder.
// master drives frames and observes results; slave is the decoder side.
interface uart_cmd_decoder_if;
  logic [8:0]  frame;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [15:0] arg;
  logic        cmd_valid;
  logic        parity_err;
  logic        proto_err;
  logic [7:0]  err_count;
  logic        busy;

  modport master (
    output frame,
    output frame_valid,
    input  cmd,
    input  arg,
    input  cmd_valid,
    input  parity_err,
    input  proto_err,
    input  err_count,
    input  busy
  );

  modport slave (
    input  frame,
    input  frame_valid,
    output cmd,
    output arg,
    output cmd_valid,
    output parity_err,
    output proto_err,
    output err_count,
    output busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART packet decoder: HEADER, CMD, ARG_H, ARG_L, CHK with even parity.
// Ports: clk, rst (async active-low), bus (slave: frame in, cmd/arg/errors out).
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_decoder_if.slave  bus
);

  localparam int TW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST =
    TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG_H,
    ST_ARG_L,
    ST_CHK
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_sh_cmd;
  logic [7:0]    r_sh_argh;
  logic [7:0]    r_sh_argl;
  logic [7:0]    r_cmd;
  logic [15:0]   r_arg;
  logic [7:0]    r_err_cnt;
  logic          r_cmd_valid;
  logic          r_parity_err;
  logic          r_proto_err;

  logic [7:0]    w_byte;
  logic [7:0]    w_sum;
  logic          w_par_ok;
  logic          w_bad;
  logic          w_good;
  logic          w_expire;
  logic          w_ld_cmd;
  logic          w_ld_argh;
  logic          w_ld_argl;
  logic          w_commit;
  logic          w_cv;
  logic          w_pe;
  logic          w_pr;
  logic          w_tmr_clr;

  assign w_byte   = bus.frame[7:0];
  assign w_sum    = r_sh_cmd ^ r_sh_argh ^ r_sh_argl;
  assign w_par_ok = (bus.frame[8] == ^w_byte);
  assign w_bad    = bus.frame_valid & ~w_par_ok;
  assign w_good   = bus.frame_valid & w_par_ok;
  // A frame in the expiry cycle wins, so expiry needs a quiet cycle.
  assign w_expire = ~bus.frame_valid
                  & (r_state != ST_IDLE)
                  & (r_timer == LAST);
  assign w_tmr_clr = bus.frame_valid | w_expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ld_cmd  = 1'b0;
    w_ld_argh = 1'b0;
    w_ld_argl = 1'b0;
    w_commit  = 1'b0;
    w_cv      = 1'b0;
    w_pe      = 1'b0;
    w_pr      = 1'b0;
    unique case (1'b1)
      w_bad: begin
        w_pe   = 1'b1;
        w_next = ST_IDLE;
      end
      w_good: begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_byte == HEADER) begin
              w_next = ST_CMD;
            end
          end
          ST_CMD: begin
            w_ld_cmd = 1'b1;
            w_next   = ST_ARG_H;
          end
          ST_ARG_H: begin
            w_ld_argh = 1'b1;
            w_next    = ST_ARG_L;
          end
          ST_ARG_L: begin
            w_ld_argl = 1'b1;
            w_next    = ST_CHK;
          end
          ST_CHK: begin
            if (w_byte == w_sum) begin
              w_commit = 1'b1;
              w_cv     = 1'b1;
            end else begin
              w_pr = 1'b1;
            end
            w_next = ST_IDLE;
          end
          default: begin
            w_next = ST_IDLE;
          end
        endcase
      end
      w_expire: begin
        w_pr   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_tmr_clr || r_state == ST_IDLE) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_cmd  <= '0;
      r_sh_argh <= '0;
      r_sh_argl <= '0;
    end else begin
      if (w_ld_cmd) begin
        r_sh_cmd <= w_byte;
      end
      if (w_ld_argh) begin
        r_sh_argh <= w_byte;
      end
      if (w_ld_argl) begin
        r_sh_argl <= w_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd <= '0;
      r_arg <= '0;
    end else if (w_commit) begin
      r_cmd <= r_sh_cmd;
      r_arg <= {r_sh_argh, r_sh_argl};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_cmd_valid  <= w_cv;
      r_parity_err <= w_pe;
      r_proto_err  <= w_pr;
    end
  end

  // Counter moves in the same edge that raises the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if ((w_pe || w_pr) && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.cmd        = r_cmd;
  assign bus.arg        = r_arg;
  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.proto_err  = r_proto_err;
  assign bus.err_count  = r_err_cnt;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder against a packet-level model.
// Checks strobes, err_count and cmd/arg every cycle plus directed cases.
module tb_uart_cmd_decoder;

  localparam int          T   = 40;
  localparam logic [7:0]  HDR = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .TIMEOUT_CYC (T),
    .HEADER      (HDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packet-level model state
  bit          m_open;
  logic [7:0]  m_pkt[$];
  int          m_cyc;
  int          m_last;
  logic [7:0]  m_cmd;
  logic [15:0] m_arg;
  logic [7:0]  m_cnt;
  logic        m_cv;
  logic        m_pe;
  logic        m_pr;

  function automatic logic [8:0] gf(input logic [7:0] b);
    return {^b, b};
  endfunction

  function automatic logic [8:0] bf(input logic [7:0] b);
    return {~(^b), b};
  endfunction

  task automatic bump();
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model(input logic v, input logic [8:0] f);
    logic [7:0] x;
    m_cv = 1'b0;
    m_pe = 1'b0;
    m_pr = 1'b0;
    if (v) begin
      m_last = m_cyc;
      if (f[8] != ^f[7:0]) begin
        m_pe   = 1'b1;
        m_open = 1'b0;
        bump();
      end else if (!m_open) begin
        if (f[7:0] == HDR) begin
          m_open = 1'b1;
          m_pkt.delete();
        end
      end else begin
        m_pkt.push_back(f[7:0]);
        if (m_pkt.size() == 4) begin
          m_open = 1'b0;
          x = m_pkt[0] ^ m_pkt[1] ^ m_pkt[2];
          if (x == m_pkt[3]) begin
            m_cv  = 1'b1;
            m_cmd = m_pkt[0];
            m_arg = {m_pkt[1], m_pkt[2]};
          end else begin
            m_pr = 1'b1;
            bump();
          end
        end
      end
    end else if (m_open && (m_cyc - m_last) == T) begin
      m_pr   = 1'b1;
      m_open = 1'b0;
      bump();
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".strobes"},
        {28'd0, bus.cmd_valid, bus.parity_err,
         bus.proto_err, bus.busy},
        {28'd0, m_cv, m_pe, m_pr, m_open});
    chk({tag, ".err_count"},
        {24'd0, bus.err_count}, {24'd0, m_cnt});
    chk({tag, ".cmd_arg"},
        {8'd0, bus.cmd, bus.arg}, {8'd0, m_cmd, m_arg});
  endtask

  task automatic cyc(input logic v, input logic [8:0] f);
    @(negedge clk);
    bus.frame_valid = v;
    bus.frame       = f;
    @(posedge clk);
    m_cyc++;
    model(v, f);
    #1;
    compare("cyc");
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 9'h000);
  endtask

  task automatic model_reset();
    m_open = 1'b0;
    m_pkt.delete();
    m_cmd  = '0;
    m_arg  = '0;
    m_cnt  = '0;
    m_cv   = 1'b0;
    m_pe   = 1'b0;
    m_pr   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst             = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame       = '0;
    #1;
    model_reset();
    compare("rst_async");
    repeat (n) begin
      @(posedge clk);
      m_cyc++;
      #1;
      compare("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] c,
                          input logic [7:0] ah,
                          input logic [7:0] al,
                          input bit corrupt);
    logic [7:0] s;
    s = c ^ ah ^ al;
    if (corrupt) s = s ^ 8'h01;
    cyc(1'b1, gf(HDR));
    cyc(1'b1, gf(c));
    cyc(1'b1, gf(ah));
    cyc(1'b1, gf(al));
    cyc(1'b1, gf(s));
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return 0;
    if (r == 6) return int'($urandom_range(1, 3));
    if (r == 7) return T - 1;
    if (r == 8) return T;
    return T + int'($urandom_range(1, 2));
  endfunction

  task automatic rand_pkt();
    logic [7:0] b[5];
    b[0] = HDR;
    b[1] = 8'($urandom);
    b[2] = 8'($urandom);
    b[3] = 8'($urandom);
    b[4] = b[1] ^ b[2] ^ b[3];
    if ($urandom_range(0, 3) == 0) b[4] = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 29) == 0) cyc(1'b1, bf(b[k]));
      else cyc(1'b1, gf(b[k]));
      if (k < 4 && $urandom_range(0, 2) == 0) idle(pick_gap());
    end
  endtask

  initial begin
    bus.frame_valid = 1'b0;
    bus.frame       = '0;
    m_cyc  = 0;
    m_last = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Nominal packet
    cyc(1'b1, 9'h0A5);
    cyc(1'b1, 9'h012);
    cyc(1'b1, 9'h134);
    cyc(1'b1, 9'h056);
    cyc(1'b1, 9'h170);
    chk("d034_cv", {31'd0, bus.cmd_valid}, 32'd1);
    chk("d034_cmd", {24'd0, bus.cmd}, 32'h12);
    chk("d034_arg", {16'd0, bus.arg}, 32'h3456);
    chk("d034_cnt", {24'd0, bus.err_count}, 32'd0);
    idle(1);

    // Wrong checksum
    cyc(1'b1, 9'h0A5);
    cyc(1'b1, 9'h012);
    cyc(1'b1, 9'h134);
    cyc(1'b1, 9'h056);
    cyc(1'b1, 9'h071);
    chk("d035_pr", {31'd0, bus.proto_err}, 32'd1);
    chk("d035_arg", {16'd0, bus.arg}, 32'h3456);
    chk("d035_cnt", {24'd0, bus.err_count}, 32'd1);
    idle(1);

    // Bad parity mid-packet
    cyc(1'b1, 9'h0A5);
    cyc(1'b1, 9'h112);
    chk("d036_pe", {31'd0, bus.parity_err}, 32'd1);
    chk("d036_busy", {31'd0, bus.busy}, 32'd0);
    send_pkt(8'h21, 8'h43, 8'h65, 1'b0);
    chk("d036_cmd", {24'd0, bus.cmd}, 32'h21);

    // Timeout, including exact-expiry frame priority
    cyc(1'b1, 9'h0A5);
    cyc(1'b1, 9'h012);
    idle(T + 5);
    chk("d037_busy", {31'd0, bus.busy}, 32'd0);
    cyc(1'b1, 9'h0A5);
    idle(T - 1);
    cyc(1'b1, 9'h012);
    chk("d026_busy", {31'd0, bus.busy}, 32'd1);
    idle(T + 1);

    // Stray good frames before a header
    cyc(1'b1, 9'h033);
    cyc(1'b1, 9'h1F1);
    send_pkt(8'h7E, 8'h00, 8'hFF, 1'b0);
    chk("d038_arg", {16'd0, bus.arg}, 32'h00FF);

    // Reset mid-packet
    cyc(1'b1, 9'h0A5);
    cyc(1'b1, 9'h012);
    cyc(1'b1, 9'h134);
    do_reset(3);
    chk("d039_cnt", {24'd0, bus.err_count}, 32'd0);
    send_pkt(8'h12, 8'h34, 8'h56, 1'b0);
    chk("d039_cmd", {24'd0, bus.cmd}, 32'h12);

    // Saturation
    for (int i = 0; i < 300; i++) cyc(1'b1, bf(8'($urandom)));
    chk("d040_sat", {24'd0, bus.err_count}, 32'hFF);
    do_reset(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) rand_pkt();
      else if (r == 6) cyc(1'b1, gf(8'($urandom)));
      else if (r == 7) cyc(1'b1, bf(8'($urandom)));
      else if (r == 8) idle(pick_gap());
      else idle(int'($urandom_range(0, 2)));
    end
    idle(T + 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
